// File: rtl/alu_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer_pkg
// Brief   : Opcode and state encodings shared by the ALU operation sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package alu_sequencer_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_NONE = 2'b11;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] S_IDLE      = 3'd0;
    localparam logic [c_STATE_W-1:0] S_ISSUE     = 3'd1;
    localparam logic [c_STATE_W-1:0] S_WAIT_COMB = 3'd2;
    localparam logic [c_STATE_W-1:0] S_WAIT_MUL  = 3'd3;
    localparam logic [c_STATE_W-1:0] S_HOLD      = 3'd4;

    function automatic logic is_legal_op(input logic [1:0] op);
        return op != OP_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_timer.sv
`default_nettype none
// ============================================================================
// Module  : alu_seq_timer
// Brief   : Saturating WAIT_MUL cycle counter. ALU_SEQ_TIMEOUT_EN widens it to
//           TIMEOUT_CYCLES and enables the timed_out flag.
// Revision: 1.0 - initial release
// ============================================================================
module alu_seq_timer #(
    parameter int MIN_MUL_CYCLES = 2
`ifdef ALU_SEQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 64
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_min_reached,
    output logic o_timed_out
);

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int c_CNT_MAX = (TIMEOUT_CYCLES > MIN_MUL_CYCLES) ? TIMEOUT_CYCLES : MIN_MUL_CYCLES;
`else
    localparam int c_CNT_MAX = MIN_MUL_CYCLES;
`endif
    localparam int c_CNT_W = (c_CNT_MAX < 1) ? 1 : $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MIN = c_CNT_W'(MIN_MUL_CYCLES);
    localparam logic [c_CNT_W-1:0] c_MAX = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_CNT_W-1:0] c_ONE = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // Saturates so a long multiply never wraps back under the masking window.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_enable && (r_cnt != c_MAX)) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_min_reached = (r_cnt >= c_MIN);

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam logic [c_CNT_W-1:0] c_TMO = c_CNT_W'(TIMEOUT_CYCLES);
    assign o_timed_out = (r_cnt == c_TMO);
`else
    assign o_timed_out = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : alu_sequencer
// Brief   : Start/Busy command sequencer feeding a 4-bit ALU and holding the
//           result until Ack. ALU_SEQ_TIMEOUT_EN adds a multiply timeout.
// Revision: 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int MIN_MUL_CYCLES = 2
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic [3:0] OpA,
    input  logic [3:0] OpB,
    input  logic [1:0] Op,
    output logic       Busy,
    output logic [3:0] AluA,
    output logic [3:0] AluB,
    output logic [1:0] AluSelect,
    output logic       AluInit,
    input  logic [7:0] AluSal,
    input  logic       AluCout,
    input  logic       AluDone,
    output logic [7:0] Result,
    output logic       Carry,
    output logic       Valid,
    input  logic       Ack,
    output logic       Err
);

    logic [c_STATE_W-1:0] r_state;
    logic [c_STATE_W-1:0] w_next_state;

    logic [3:0] r_alu_a;
    logic [3:0] r_alu_b;
    logic [1:0] r_alu_sel;
    logic [7:0] r_result;
    logic       r_carry;
    logic       r_err;

    logic w_min_reached;
    logic w_timed_out;
    logic w_in_wait_mul;
    logic w_mul_done;
    logic w_accept;

    assign w_in_wait_mul = (r_state == S_WAIT_MUL);
    assign w_mul_done    = w_in_wait_mul && w_min_reached && AluDone;
    assign w_accept      = (r_state == S_IDLE) && Start;

    alu_seq_timer #(
        .MIN_MUL_CYCLES (MIN_MUL_CYCLES)
`ifdef ALU_SEQ_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
`endif
    ) u_timer (
        .clk           (Clk),
        .rst           (Rst),
        .i_clear       (!w_in_wait_mul),
        .i_enable      (w_in_wait_mul),
        .o_min_reached (w_min_reached),
        .o_timed_out   (w_timed_out)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (Start) begin
                    w_next_state = is_legal_op(Op) ? S_ISSUE : S_HOLD;
                end
            end
            S_ISSUE: begin
                w_next_state = (r_alu_sel == OP_MUL) ? S_WAIT_MUL : S_WAIT_COMB;
            end
            S_WAIT_COMB: begin
                w_next_state = S_HOLD;
            end
            S_WAIT_MUL: begin
                if (w_mul_done || w_timed_out) begin
                    w_next_state = S_HOLD;
                end
            end
            S_HOLD: begin
                if (Ack) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_comb begin
        Busy    = (r_state != S_IDLE);
        Valid   = (r_state == S_HOLD);
        AluInit = (r_state == S_ISSUE) && (r_alu_sel == OP_MUL);
    end

    // Operands only move on an accepted Start, so the ALU sees stable inputs
    // for the whole operation and through HOLD.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_sel <= OP_ADD;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_accept) begin
            r_alu_a   <= OpA;
            r_alu_b   <= OpB;
            r_alu_sel <= Op;
            if (!is_legal_op(Op)) begin
                r_result <= '0;
                r_carry  <= 1'b0;
                r_err    <= 1'b1;
            end
        end else if (r_state == S_WAIT_COMB) begin
            r_result <= AluSal;
            r_carry  <= AluCout;
            r_err    <= 1'b0;
        end else if (w_mul_done) begin
            r_result <= AluSal;
            r_carry  <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_in_wait_mul && w_timed_out) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_err    <= 1'b1;
        end
    end

    assign AluA      = r_alu_a;
    assign AluB      = r_alu_b;
    assign AluSelect = r_alu_sel;
    assign Result    = r_result;
    assign Carry     = r_carry;
    assign Err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_sequencer
// Brief   : Scoreboard bench for alu_sequencer with a behavioural 4-bit ALU.
//           Define ALU_SEQ_TIMEOUT_EN to include the multiply timeout case.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Start;
    logic [3:0] OpA;
    logic [3:0] OpB;
    logic [1:0] Op;
    logic       Busy;
    logic [3:0] AluA;
    logic [3:0] AluB;
    logic [1:0] AluSelect;
    logic       AluInit;
    logic [7:0] AluSal;
    logic       AluCout;
    logic       AluDone;
    logic [7:0] Result;
    logic       Carry;
    logic       Valid;
    logic       Ack;
    logic       Err;

    always #5 Clk = ~Clk;

    alu_sequencer dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .OpA       (OpA),
        .OpB       (OpB),
        .Op        (Op),
        .Busy      (Busy),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluSelect (AluSelect),
        .AluInit   (AluInit),
        .AluSal    (AluSal),
        .AluCout   (AluCout),
        .AluDone   (AluDone),
        .Result    (Result),
        .Carry     (Carry),
        .Valid     (Valid),
        .Ack       (Ack),
        .Err       (Err)
    );

    // Behavioural ALU: multiplier raises Done 6 cycles after Init and keeps it
    // high (stale) until the next Init; product is only visible while done.
    logic [3:0] mul_cnt = 4'd0;
    logic       mul_kill = 1'b0;
    logic       stale_done = 1'b0;
    logic       mul_done;
    logic [4:0] add_sum;
    logic [4:0] sub_sum;

    always @(posedge Clk) begin
        if (AluInit) mul_cnt <= 4'd1;
        else if (mul_cnt != 4'd0 && mul_cnt < 4'd6) mul_cnt <= mul_cnt + 4'd1;
    end

    assign mul_done = (mul_cnt == 4'd6) && !mul_kill;
    assign add_sum  = {1'b0, AluA} + {1'b0, AluB};
    assign sub_sum  = {1'b0, AluA} + {1'b0, ~AluB} + 5'd1;
    assign AluDone  = mul_done || stale_done;

    always_comb begin
        AluSal  = 8'h00;
        AluCout = 1'b0;
        case (AluSelect)
            2'b00: begin AluSal = {4'h0, add_sum[3:0]}; AluCout = add_sum[4]; end
            2'b01: begin AluSal = {4'h0, sub_sum[3:0]}; AluCout = sub_sum[4]; end
            2'b10: AluSal = mul_done ? ({4'h0, AluA} * {4'h0, AluB}) : 8'h00;
            default: AluSal = 8'h00;
        endcase
    end

    typedef struct packed {
        logic [7:0] result;
        logic       carry;
        logic       err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   init_cnt = 0;
    logic seen = 1'b0;

    always @(negedge Clk) begin
        exp_t e;
        if (AluInit) init_cnt++;
        if (Valid && !seen) begin
            seen = 1'b1;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid actual Result=%0h Carry=%0b Err=%0b required no output", Result, Carry, Err);
            end else begin
                e = exp_q.pop_front();
                if ({Result, Carry, Err} !== e) begin
                    bad++;
                    $display("FAIL scoreboard actual Result=%0h Carry=%0b Err=%0b required Result=%0h Carry=%0b Err=%0b",
                             Result, Carry, Err, e.result, e.carry, e.err);
                end
            end
        end
        if (!Valid) seen = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Issue a command and measure edges from the accepting edge until Valid.
    task automatic issue(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] er, input logic ec, input logic ee,
                         input int lat, input logic stale, input string name);
        int n;
        exp_t e;
        @(negedge Clk);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        e.result = er; e.carry = ec; e.err = ee;
        exp_q.push_back(e);
        @(posedge Clk); #1;
        Start = 1'b0;
        if (stale) stale_done = 1'b1;
        check({name, "_busy"}, {31'd0, Busy}, 32'd1);
        n = 0;
        while (!Valid && n < 200) begin
            @(posedge Clk); #1;
            n++;
            if (n == 3) stale_done = 1'b0;
        end
        stale_done = 1'b0;
        check({name, "_latency"}, n, lat);
    endtask

    task automatic ack_now(input string name);
        Ack = 1'b1;
        @(posedge Clk); #1;
        Ack = 1'b0;
        check({name, "_ack_idle"}, {30'd0, Busy, Valid}, 32'd0);
    endtask

    initial begin
        int inits_before;
        Rst = 1'b1; Start = 1'b0; OpA = 4'd0; OpB = 4'd0; Op = 2'b00; Ack = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("reset_outputs", {9'd0, Busy, AluA, AluB, AluSelect, AluInit, Result, Carry, Valid, Err}, 32'd0);
        Rst = 1'b0;

        issue(2'b00, 4'd9, 4'd8, 8'h01, 1'b1, 1'b0, 2, 1'b0, "add_9_8");
        ack_now("add_9_8");
        issue(2'b01, 4'd5, 4'd3, 8'h02, 1'b1, 1'b0, 2, 1'b0, "sub_5_3");
        ack_now("sub_5_3");
        issue(2'b01, 4'd3, 4'd5, 8'h0E, 1'b0, 1'b0, 2, 1'b0, "sub_3_5");
        ack_now("sub_3_5");
        issue(2'b00, 4'd15, 4'd15, 8'h0E, 1'b1, 1'b0, 2, 1'b0, "add_15_15");
        ack_now("add_15_15");

        issue(2'b10, 4'd15, 4'd15, 8'd225, 1'b0, 1'b0, 7, 1'b1, "mul_15_15_stale");
        ack_now("mul_15_15");
        issue(2'b10, 4'd3, 4'd4, 8'd12, 1'b0, 1'b0, 7, 1'b0, "mul_3_4");
        ack_now("mul_3_4");

        inits_before = init_cnt;
        issue(2'b11, 4'd5, 4'd6, 8'h00, 1'b0, 1'b1, 0, 1'b0, "illegal");
        ack_now("illegal");
        check("illegal_no_init", init_cnt - inits_before, 32'd0);

        // Backpressure: HOLD must be frozen while Start toggles with new operands.
        issue(2'b00, 4'd7, 4'd2, 8'h09, 1'b0, 1'b0, 2, 1'b0, "add_bp");
        for (int i = 0; i < 10; i++) begin
            Start = i[0]; OpA = 4'hF; OpB = 4'hE; Op = 2'b01;
            @(posedge Clk); #1;
            check("bp_hold", {13'd0, Valid, Busy, Result, AluA, AluB, AluSelect}, {13'd0, 1'b1, 1'b1, 8'h09, 4'd7, 4'd2, 2'b00});
        end
        Start = 1'b0;
        ack_now("add_bp");

        // Ack already high: one HOLD cycle; Start on the completing edge is dropped.
        Ack = 1'b1;
        issue(2'b00, 4'd1, 4'd1, 8'h02, 1'b0, 1'b0, 2, 1'b0, "add_early_ack");
        Start = 1'b1; Op = 2'b00; OpA = 4'd2; OpB = 4'd2;
        @(posedge Clk); #1;
        check("early_ack_start_ignored", {30'd0, Busy, Valid}, 32'd0);
        Start = 1'b0; Ack = 1'b0;
        @(posedge Clk); #1;
        check("early_ack_stays_idle", {31'd0, Busy}, 32'd0);

        // Reset during WAIT_MUL; the model's late Done must not produce output.
        @(negedge Clk);
        Start = 1'b1; Op = 2'b10; OpA = 4'd5; OpB = 4'd5;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("rst_mid_outputs", {9'd0, Busy, AluA, AluB, AluSelect, AluInit, Result, Carry, Valid, Err}, 32'd0);
        Rst = 1'b0;
        repeat (8) @(posedge Clk);
        #1;
        check("rst_mid_quiet", {30'd0, Busy, Valid}, 32'd0);
        issue(2'b00, 4'd4, 4'd3, 8'h07, 1'b0, 1'b0, 2, 1'b0, "add_after_rst");
        ack_now("add_after_rst");

`ifdef ALU_SEQ_TIMEOUT_EN
        mul_kill = 1'b1;
        issue(2'b10, 4'd2, 4'd3, 8'h00, 1'b0, 1'b1, 66, 1'b0, "mul_timeout");
        ack_now("mul_timeout");
        mul_kill = 1'b0;
        check("init_pulses", init_cnt, 32'd4);
`else
        check("init_pulses", init_cnt, 32'd3);
`endif

        repeat (2) @(posedge Clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
